// File: rtl/rom_dual_address_pkg.sv
// Shared content image for the dual-port lookup ROM.
// Entry k is the base pattern, stretched or truncated to DATA_W, rotated left by 8*k bits.
package rom_dual_address_pkg;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 64;
    localparam int ROM_DEPTH = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] rom_word_t;
    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [ROM_DEPTH-1:0][DATA_W-1:0] rom_image_t;

    localparam logic [63:0] ROM_BASE = 64'h0123456789ABCDEF;

    // Bit i of the stretched pattern repeats the 64-bit base; rotation is modulo DATA_W.
    function automatic rom_image_t build_rom_image();
        rom_image_t image;
        rom_word_t  pattern;
        int         shift;
        int         src;
        for (int i = 0; i < DATA_W; i++) begin
            pattern[i] = ROM_BASE[i % 64];
        end
        for (int k = 0; k < ROM_DEPTH; k++) begin
            shift = (8 * k) % DATA_W;
            for (int i = 0; i < DATA_W; i++) begin
                src         = (i - shift + DATA_W) % DATA_W;
                image[k][i] = pattern[src];
            end
        end
        return image;
    endfunction

    localparam rom_image_t ROM_CONTENT = build_rom_image();

endpackage

// File: rtl/rom_read_port.sv
// One synchronous read port of the shared ROM image.
// The word for the sampled address is registered every cycle; reset clears it.
module rom_read_port
    import rom_dual_address_pkg::*;
#(
    parameter int ADDR_W = rom_dual_address_pkg::ADDR_W,
    parameter int DATA_W = rom_dual_address_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= ROM_CONTENT[addr];
        end
    end

endmodule

// File: rtl/rom_dual_address.sv
// Two independent registered read ports over one constant content image.
// Ports never conflict, so both may address the same entry in the same cycle.
module rom_dual_address
    import rom_dual_address_pkg::*;
#(
    parameter int ADDR_W = rom_dual_address_pkg::ADDR_W,
    parameter int DATA_W = rom_dual_address_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2
);

    rom_read_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_port1 (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr1),
        .dout (dout1)
    );

    rom_read_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_port2 (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr2),
        .dout (dout2)
    );

endmodule

// File: tb/tb_rom_dual_address.sv
// Directed bench for rom_dual_address: a scoreboard queue per port holds the word
// expected one edge after each address is driven.
module tb_rom_dual_address;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [63:0] dout1;
    logic [63:0] dout2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp1_q[$];
    logic [63:0] exp2_q[$];

    logic [63:0] k_table [8] = '{
        64'h0123456789ABCDEF, 64'h23456789ABCDEF01,
        64'h456789ABCDEF0123, 64'h6789ABCDEF012345,
        64'h89ABCDEF01234567, 64'hABCDEF0123456789,
        64'hCDEF0123456789AB, 64'hEF0123456789ABCD
    };

    rom_dual_address dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr1(addr1),
        .addr2(addr2),
        .dout1(dout1),
        .dout2(dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive both addresses away from the active edge and queue their expected words.
    task automatic apply_stimulus(input int a1, input int a2);
        @(negedge clk);
        addr1 = 3'(a1);
        addr2 = 3'(a2);
        exp1_q.push_back(k_table[a1]);
        exp2_q.push_back(k_table[a2]);
    endtask

    task automatic check_output(input string tag);
        logic [63:0] e1;
        logic [63:0] e2;
        @(posedge clk);
        #1;
        if (exp1_q.size() == 0 || exp2_q.size() == 0) begin
            compare({tag, "_queue"}, 64'(exp1_q.size()), 64'd1);
        end else begin
            e1 = exp1_q.pop_front();
            e2 = exp2_q.pop_front();
            compare({tag, "_dout1"}, dout1, e1);
            compare({tag, "_dout2"}, dout2, e2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr1 = 3'd5;
        addr2 = 3'd2;

        // Reset held for two edges with arbitrary addresses.
        repeat (2) @(posedge clk);
        #1;
        compare("reset_dout1", dout1, 64'h0);
        compare("reset_dout2", dout2, 64'h0);

        // Release with the opposite-corner addresses already applied.
        @(negedge clk);
        addr1 = 3'd0;
        addr2 = 3'd7;
        rst_n = 1'b1;
        exp1_q.push_back(k_table[0]);
        exp2_q.push_back(k_table[7]);
        #1;
        compare("release0_dout1", dout1, 64'h0);
        check_output("opposite");

        // Full sweep in opposite directions.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(i, 7 - i);
            check_output($sformatf("sweep%0d", i));
        end

        // Midpoint against literal values.
        apply_stimulus(3, 4);
        check_output("midpoint");
        compare("midpoint_lit1", dout1, 64'h6789ABCDEF012345);
        compare("midpoint_lit2", dout2, 64'h89ABCDEF01234567);

        apply_stimulus(5, 5);
        check_output("same_addr");

        // Hold: constant addresses keep outputs stable.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(2, 6);
            check_output($sformatf("hold%0d", i));
        end

        // Only port 1 moves; check it updates after exactly one edge.
        @(negedge clk);
        addr1 = 3'd4;
        #1;
        compare("addr1_chg_pre_dout1", dout1, k_table[2]);
        exp1_q.push_back(k_table[4]);
        exp2_q.push_back(k_table[6]);
        check_output("addr1_chg");

        // Mid-stream reset clears outputs without a clock edge.
        apply_stimulus(7, 1);
        check_output("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_rst_dout1", dout1, 64'h0);
        compare("async_rst_dout2", dout2, 64'h0);
        @(negedge clk);
        addr1 = 3'd3;
        addr2 = 3'd0;
        @(posedge clk);
        #1;
        compare("rst_hold_dout1", dout1, 64'h0);
        compare("rst_hold_dout2", dout2, 64'h0);

        // Release: zero until the first edge, then the current addresses.
        @(negedge clk);
        addr1 = 3'd1;
        addr2 = 3'd6;
        rst_n = 1'b1;
        exp1_q.push_back(k_table[1]);
        exp2_q.push_back(k_table[6]);
        #1;
        compare("release_pre_dout1", dout1, 64'h0);
        compare("release_pre_dout2", dout2, 64'h0);
        check_output("release");
        compare("release_lit1", dout1, 64'h23456789ABCDEF01);
        compare("release_lit2", dout2, 64'hCDEF0123456789AB);

        // Random pairs.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
            check_output($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
